traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_light_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Main-road / side-road intersection controller. It runs on the 100 MHz
// system clock and advances its phase timers once per rising edge of the
// 1 Hz level clk1. The main road rests in green until a side-road vehicle
// is seen. A night request switches both roads to flashing yellow.
//
// Parameters (seconds, each 1..63):
//   T_MG  main-road minimum green
//   T_SG  side-road green
//   T_Y   yellow, both roads
//   T_AR  all-red clearance
//
// Ports:
//   clk100M   in   100 MHz system clock, the only clock
//   clr       in   synchronous active-high reset
//   clk1      in   1 Hz square wave, synchronous to clk100M
//   car       in   side-road vehicle sensor (1 = waiting)
//   night     in   night flash-mode request (level)
//   main_rgy  out  main-road lamps {red, yellow, green}
//   side_rgy  out  side-road lamps {red, yellow, green}
//   remain    out  seconds left in the current phase
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
  parameter int T_MG = 30,
  parameter int T_SG = 20,
  parameter int T_Y  = 3,
  parameter int T_AR = 2
) (
  input  logic       clk100M,
  input  logic       clr,
  input  logic       clk1,
  input  logic       car,
  input  logic       night,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic [5:0] remain
);

  // Phase encoding. FLASH is entered from any phase on a night request.
  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MY    = 3'd1,
    S_AR1   = 3'd2,
    S_SG    = 3'd3,
    S_SY    = 3'd4,
    S_AR2   = 3'd5,
    S_FLASH = 3'd6
  } state_t;

  // Lamp patterns {red, yellow, green}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // The value remain takes when a phase is entered (duration - 1).
  localparam logic [5:0] LD_MG = 6'(T_MG - 1);
  localparam logic [5:0] LD_SG = 6'(T_SG - 1);
  localparam logic [5:0] LD_Y  = 6'(T_Y - 1);
  localparam logic [5:0] LD_AR = 6'(T_AR - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [5:0] remain_q, remain_d;
  logic       flash_q, flash_d;
  logic       clk1_d_q;
  logic       tick;

  // One-cycle pulse on each rising edge of clk1. The delayed copy is preset
  // to 1 on reset, so a clk1 that is already high when reset is released
  // does not count as an edge.
  assign tick = clk1 & ~clk1_d_q;

  // ---------------------------------------------------------------------------
  // Phase sequencing helpers
  // ---------------------------------------------------------------------------
  function automatic state_t succ(input state_t s);
    state_t n;
    case (s)
      S_MG:    n = S_MY;
      S_MY:    n = S_AR1;
      S_AR1:   n = S_SG;
      S_SG:    n = S_SY;
      S_SY:    n = S_AR2;
      S_AR2:   n = S_MG;
      default: n = S_MG;
    endcase
    return n;
  endfunction

  function automatic logic [5:0] load_for(input state_t s);
    logic [5:0] v;
    case (s)
      S_MG:          v = LD_MG;
      S_MY, S_SY:    v = LD_Y;
      S_AR1, S_AR2:  v = LD_AR;
      S_SG:          v = LD_SG;
      default:       v = 6'd0;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk100M) begin
    if (clr) begin
      state_q  <= S_MG;
      remain_q <= LD_MG;
      flash_q  <= 1'b0;
      clk1_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      flash_q  <= flash_d;
      clk1_d_q <= clk1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Inputs car and night are only looked at in tick
  // cycles; between ticks everything holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    flash_d  = flash_q;

    if (tick) begin
      if (night) begin
        // Night wins over all timing. Flash starts lit and toggles each
        // second for as long as the request stays.
        state_d  = S_FLASH;
        remain_d = 6'd0;
        flash_d  = (state_q == S_FLASH) ? ~flash_q : 1'b1;
      end else if (state_q == S_FLASH) begin
        // Leave flash through all-red so both roads are cleared before
        // the main road gets green again.
        state_d  = S_AR2;
        remain_d = LD_AR;
        flash_d  = 1'b0;
      end else if (remain_q != 6'd0) begin
        remain_d = remain_q - 6'd1;
      end else if ((state_q == S_MG) && !car) begin
        // Main green rests at zero until a side-road vehicle is seen.
        state_d  = S_MG;
        remain_d = 6'd0;
      end else begin
        state_d  = succ(state_q);
        remain_d = load_for(succ(state_q));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from registered state only. While clr is high the
  // reset pattern is shown immediately, even before the first clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    main_rgy = LAMP_R;
    side_rgy = LAMP_R;
    remain   = remain_q;

    if (clr) begin
      main_rgy = LAMP_G;
      side_rgy = LAMP_R;
      remain   = LD_MG;
    end else begin
      case (state_q)
        S_MG: begin
          main_rgy = LAMP_G;
          side_rgy = LAMP_R;
        end
        S_MY: begin
          main_rgy = LAMP_Y;
          side_rgy = LAMP_R;
        end
        S_AR1, S_AR2: begin
          main_rgy = LAMP_R;
          side_rgy = LAMP_R;
        end
        S_SG: begin
          main_rgy = LAMP_R;
          side_rgy = LAMP_G;
        end
        S_SY: begin
          main_rgy = LAMP_R;
          side_rgy = LAMP_Y;
        end
        S_FLASH: begin
          main_rgy = flash_q ? LAMP_Y : LAMP_OFF;
          side_rgy = flash_q ? LAMP_Y : LAMP_OFF;
        end
        default: begin
          main_rgy = LAMP_R;
          side_rgy = LAMP_R;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//
// Directed bench for traffic_light_ctrl with T_MG=4, T_SG=3, T_Y=2, T_AR=1.
// The stimulus process drives clk1/car/night/clr and pushes the expected
// lamps and remain value into a queue. A monitor pops and compares on the
// falling clock edge whenever a check is requested. Safety properties on
// the lamps and on tick width are watched on every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_traffic_light_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       clk1 = 1'b0;
  logic       car = 1'b1;
  logic       night = 1'b0;
  logic [2:0] main_rgy;
  logic [2:0] side_rgy;
  logic [5:0] remain;

  traffic_light_ctrl #(
    .T_MG(4),
    .T_SG(3),
    .T_Y (2),
    .T_AR(1)
  ) dut (
    .clk100M (clk),
    .clr     (clr),
    .clk1    (clk1),
    .car     (car),
    .night   (night),
    .main_rgy(main_rgy),
    .side_rgy(side_rgy),
    .remain  (remain)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] m;
    logic [2:0] s;
    logic [5:0] r;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // ---------------------------------------------------------------------------
  // Monitor: one line per checked transaction
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_req) begin
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL no_expectation: got main=%b side=%b remain=%0d, none queued",
                 main_rgy, side_rgy, remain);
      end else begin
        e = exp_q.pop_front();
        if (main_rgy !== e.m || side_rgy !== e.s || remain !== e.r) begin
          n_err++;
          $display("FAIL %s: got main=%b side=%b remain=%0d, want main=%b side=%b remain=%0d",
                   e.name, main_rgy, side_rgy, remain, e.m, e.s, e.r);
        end else begin
          $display("ok   %s: main=%b side=%b remain=%0d", e.name, main_rgy, side_rgy, remain);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Whole-run safety watch
  // ---------------------------------------------------------------------------
  logic tick_prev = 1'b0;
  logic flash_sig;
  assign flash_sig = (main_rgy == side_rgy) && !main_rgy[2] && !main_rgy[0];

  always @(negedge clk) begin
    if (!clr && !flash_sig) begin
      if (!main_rgy[2] && !side_rgy[2]) begin
        n_cmp++;
        n_err++;
        $display("FAIL red_overlap: got main=%b side=%b, want at least one red", main_rgy, side_rgy);
      end
      if ((main_rgy[1:0] != 2'b00) && (side_rgy[1:0] != 2'b00)) begin
        n_cmp++;
        n_err++;
        $display("FAIL go_overlap: got main=%b side=%b, want one road stopped", main_rgy, side_rgy);
      end
    end
    if (dut.tick === 1'b1 && tick_prev === 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_width: got tick high 2 cycles, want 1");
    end
    tick_prev <= dut.tick;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic expect_out(input string name, input logic [2:0] m,
                            input logic [2:0] s, input logic [5:0] r);
    exp_t e;
    e.name = name;
    e.m    = m;
    e.s    = s;
    e.r    = r;
    exp_q.push_back(e);
    chk_req = 1'b1;
    @(posedge clk);
    #1 chk_req = 1'b0;
  endtask

  // One clk1 period: rise, hold high a few cycles, fall, settle.
  task automatic tick1();
    @(posedge clk);
    #1 clk1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 clk1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick_expect(input string name, input logic [2:0] m,
                             input logic [2:0] s, input logic [5:0] r);
    tick1();
    expect_out(name, m, s, r);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset with clk1 high; check while held and after a long idle.
    clk1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_out("in_reset", G, R, 6'd3);
    clr = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    expect_out("idle_after_reset", G, R, 6'd3);
    clk1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("clk1_fall_no_tick", G, R, 6'd3);

    // Full cycle with a car waiting.
    tick_expect("mg2",  G, R, 6'd2);
    tick_expect("mg1",  G, R, 6'd1);
    tick_expect("mg0",  G, R, 6'd0);
    tick_expect("my1",  Y, R, 6'd1);
    tick_expect("my0",  Y, R, 6'd0);
    tick_expect("ar1",  R, R, 6'd0);
    tick_expect("sg2",  R, G, 6'd2);
    tick_expect("sg1",  R, G, 6'd1);
    tick_expect("sg0",  R, G, 6'd0);
    tick_expect("sy1",  R, Y, 6'd1);
    tick_expect("sy0",  R, Y, 6'd0);
    tick_expect("ar2",  R, R, 6'd0);
    tick_expect("mg3",  G, R, 6'd3);

    // No car: main green counts down and then rests.
    car = 1'b0;
    tick_expect("nc_mg2", G, R, 6'd2);
    tick_expect("nc_mg1", G, R, 6'd1);
    tick_expect("nc_mg0", G, R, 6'd0);
    for (int i = 0; i < 10; i++) tick_expect("nc_hold", G, R, 6'd0);

    // Car pulse between ticks is not seen.
    car = 1'b1;
    @(posedge clk);
    #1 car = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("car_pulse_idle", G, R, 6'd0);
    tick_expect("car_pulse_lost", G, R, 6'd0);

    // Car present on a tick releases main green.
    car = 1'b1;
    tick_expect("car_on_tick_my1", Y, R, 6'd1);

    // Move to SG remain=1, then night mode.
    tick_expect("my0_b", Y, R, 6'd0);
    tick_expect("ar1_b", R, R, 6'd0);
    tick_expect("sg2_b", R, G, 6'd2);
    tick_expect("sg1_b", R, G, 6'd1);
    night = 1'b1;
    tick_expect("flash_on",  Y, Y, 6'd0);
    tick_expect("flash_off", O, O, 6'd0);
    tick_expect("flash_on2", Y, Y, 6'd0);
    night = 1'b0;
    tick_expect("flash_exit_ar2", R, R, 6'd0);
    tick_expect("resume_mg3",     G, R, 6'd3);

    // Walk to SY remain=1, then reset coinciding with a tick.
    tick_expect("mg2_c", G, R, 6'd2);
    tick_expect("mg1_c", G, R, 6'd1);
    tick_expect("mg0_c", G, R, 6'd0);
    tick_expect("my1_c", Y, R, 6'd1);
    tick_expect("my0_c", Y, R, 6'd0);
    tick_expect("ar1_c", R, R, 6'd0);
    tick_expect("sg2_c", R, G, 6'd2);
    tick_expect("sg1_c", R, G, 6'd1);
    tick_expect("sg0_c", R, G, 6'd0);
    tick_expect("sy1_c", R, Y, 6'd1);
    @(posedge clk);
    #1 clk1 = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 clk1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_over_tick", G, R, 6'd3);
    tick_expect("after_reset_mg2", G, R, 6'd2);

    // Reset while flashing.
    night = 1'b1;
    tick_expect("flash_again", Y, Y, 6'd0);
    night = 1'b0;
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_in_flash", G, R, 6'd3);

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
